// File: rtl/door_pkg.sv
// Shared types and helpers for the keypad door controller.
package door_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    GRANT   = 3'd2,
    DENY    = 3'd3,
    LOCKOUT = 3'd4
  } state_t;

  localparam int DIGIT_W      = 2;
  localparam int MAX_CODE_LEN = 16;

  // Digit i of a packed code; digit0 occupies the least significant bits.
  function automatic logic [DIGIT_W-1:0] digit_at(
    input logic [DIGIT_W*MAX_CODE_LEN-1:0] code,
    input int unsigned                     i
  );
    return code[i*DIGIT_W +: DIGIT_W];
  endfunction

  // True when exactly one button rose this cycle.
  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'b0) && ((v & (v - 4'd1)) == 4'b0);
  endfunction

  // Index of the lowest set bit; only meaningful when is_onehot() holds.
  function automatic logic [DIGIT_W-1:0] btn_index(input logic [3:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else           return 2'd3;
  endfunction

endpackage

// File: rtl/door_tick_gen.sv
// Timing prescaler: one-cycle tick every TICK_DIV cycles, restartable.
module door_tick_gen #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_eff;

  // A restart makes the current cycle position 0 of a fresh tick period.
  always_comb begin
    cnt_eff = restart ? '0 : cnt;
    tick    = (cnt_eff == TERMINAL);
  end

  // Advance the prescaler, wrapping to 0 after the terminal count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt_eff + CNT_W'(1);
  end

endmodule

// File: rtl/door_access_ctrl.sv
// Keypad door lock sequencer: code entry, grant/deny timing, lockout.
module door_access_ctrl
  import door_pkg::*;
#(
  parameter int CODE_LEN      = 4,
  parameter int TICK_DIV      = 50000000,
  parameter int TIMEOUT_TICKS = 10,
  parameter int UNLOCK_TICKS  = 3,
  parameter int DENY_TICKS    = 4,
  parameter int MAX_FAIL      = 3,
  parameter int LOCKOUT_TICKS = 30,
  parameter logic [2*CODE_LEN-1:0] DEFAULT_CODE = 8'b11_01_10_00
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            btn,
  input  logic                  code_wr_en,
  input  logic [2*CODE_LEN-1:0] code_wr_data,
  output logic                  unlock,
  output logic                  green_led,
  output logic                  red_led,
  output logic                  locked_out,
  output logic [1:0]            fail_cnt,
  output logic [2:0]            state_o
);

  localparam int IDX_W  = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int MAX_A  = (TIMEOUT_TICKS > UNLOCK_TICKS) ? TIMEOUT_TICKS : UNLOCK_TICKS;
  localparam int MAX_B  = (DENY_TICKS > LOCKOUT_TICKS) ? DENY_TICKS : LOCKOUT_TICKS;
  localparam int MAX_T  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TCNT_W = $clog2(MAX_T + 1);

  localparam logic [IDX_W-1:0]  LAST_IDX     = IDX_W'(CODE_LEN - 1);
  localparam logic [TCNT_W-1:0] TIMEOUT_LAST = TCNT_W'(TIMEOUT_TICKS - 1);
  localparam logic [TCNT_W-1:0] UNLOCK_LAST  = TCNT_W'(UNLOCK_TICKS - 1);
  localparam logic [TCNT_W-1:0] DENY_LAST    = TCNT_W'(DENY_TICKS - 1);
  localparam logic [TCNT_W-1:0] LOCKOUT_LAST = TCNT_W'(LOCKOUT_TICKS - 1);
  localparam logic [1:0]        FAIL_MAX     = 2'(MAX_FAIL);

  state_t                state;
  logic [3:0]            btn_q;
  logic [2*CODE_LEN-1:0] code_reg;
  logic [IDX_W-1:0]      idx;
  logic                  err;
  logic [TCNT_W-1:0]     tick_cnt;
  logic                  tick_restart;
  logic                  blink;
  logic                  tick;

  logic [3:0]            rise;
  logic                  press_evt;
  logic                  digit_miss;

  door_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .reset   (reset),
    .restart (tick_restart),
    .tick    (tick)
  );

  assign state_o = state;

  // Rising-edge detect on the keypad and judgement of the current digit.
  always_comb begin
    rise       = btn & ~btn_q;
    press_evt  = (rise != 4'b0);
    digit_miss = !is_onehot(rise) ||
                 (btn_index(rise) != digit_at(32'(code_reg), 32'(idx)));
  end

  // Main sequencer; outputs are registered decodes of the previous state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      btn_q        <= 4'b0;
      code_reg     <= DEFAULT_CODE;
      idx          <= '0;
      err          <= 1'b0;
      tick_cnt     <= '0;
      tick_restart <= 1'b0;
      blink        <= 1'b0;
      fail_cnt     <= 2'd0;
      unlock       <= 1'b0;
      green_led    <= 1'b0;
      red_led      <= 1'b0;
      locked_out   <= 1'b0;
    end else begin
      btn_q        <= btn;
      tick_restart <= 1'b0;
      unlock       <= (state == GRANT);
      green_led    <= (state == GRANT);
      red_led      <= (state == LOCKOUT) || ((state == DENY) && blink);
      locked_out   <= (state == LOCKOUT);

      case (state)
        IDLE: begin
          if (press_evt) begin
            state        <= ENTRY;
            idx          <= IDX_W'(1);
            err          <= digit_miss;
            tick_cnt     <= '0;
            tick_restart <= 1'b1;
          end else if (code_wr_en) begin
            code_reg <= code_wr_data;
          end
        end

        ENTRY: begin
          if (press_evt) begin
            tick_cnt     <= '0;
            tick_restart <= 1'b1;
            if (idx == LAST_IDX) begin
              idx   <= '0;
              err   <= 1'b0;
              blink <= 1'b1;
              if (err || digit_miss) begin
                state    <= DENY;
                fail_cnt <= (fail_cnt == FAIL_MAX) ? fail_cnt : fail_cnt + 2'd1;
              end else begin
                state    <= GRANT;
                fail_cnt <= 2'd0;
              end
            end else begin
              idx <= idx + IDX_W'(1);
              err <= err || digit_miss;
            end
          end else if (tick) begin
            if (tick_cnt == TIMEOUT_LAST) begin
              state        <= IDLE;
              idx          <= '0;
              err          <= 1'b0;
              tick_cnt     <= '0;
              tick_restart <= 1'b1;
            end else begin
              tick_cnt <= tick_cnt + TCNT_W'(1);
            end
          end
        end

        GRANT: begin
          if (tick) begin
            if (tick_cnt == UNLOCK_LAST) begin
              state        <= IDLE;
              tick_cnt     <= '0;
              tick_restart <= 1'b1;
            end else begin
              tick_cnt <= tick_cnt + TCNT_W'(1);
            end
          end
        end

        DENY: begin
          if (tick) begin
            blink <= ~blink;
            if (tick_cnt == DENY_LAST) begin
              state        <= (fail_cnt == FAIL_MAX) ? LOCKOUT : IDLE;
              tick_cnt     <= '0;
              tick_restart <= 1'b1;
            end else begin
              tick_cnt <= tick_cnt + TCNT_W'(1);
            end
          end
        end

        LOCKOUT: begin
          if (tick) begin
            if (tick_cnt == LOCKOUT_LAST) begin
              state        <= IDLE;
              fail_cnt     <= 2'd0;
              tick_cnt     <= '0;
              tick_restart <= 1'b1;
            end else begin
              tick_cnt <= tick_cnt + TCNT_W'(1);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_door_access_ctrl.sv
// Bench for door_access_ctrl: cycle-level reference model feeding an
// expected-output queue, popped and compared by a negedge monitor.
module tb_door_access_ctrl;

  localparam int TICK_DIV    = 4;
  localparam int CODE_LEN    = 4;
  localparam int MAX_FAIL    = 3;
  localparam int TIMEOUT_CYC = 10 * TICK_DIV;
  localparam int UNLOCK_CYC  = 3 * TICK_DIV;
  localparam int DENY_CYC    = 4 * TICK_DIV;
  localparam int LOCKOUT_CYC = 30 * TICK_DIV;
  localparam int W           = 9;
  localparam logic [7:0] DEF_CODE = 8'b11_01_10_00;

  localparam int M_IDLE = 0, M_ENTRY = 1, M_GRANT = 2, M_DENY = 3, M_LOCK = 4;

  // Clock / reset
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn = 4'b0;
  logic       code_wr_en = 1'b0;
  logic [7:0] code_wr_data = 8'h00;

  logic       unlock, green_led, red_led, locked_out;
  logic [1:0] fail_cnt;
  logic [2:0] state_o;

  always #5 clk = ~clk;

  door_access_ctrl #(
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn          (btn),
    .code_wr_en   (code_wr_en),
    .code_wr_data (code_wr_data),
    .unlock       (unlock),
    .green_led    (green_led),
    .red_led      (red_led),
    .locked_out   (locked_out),
    .fail_cnt     (fail_cnt),
    .state_o      (state_o)
  );

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic [W-1:0] mon_exp, mon_act;

  // Reference model: mode, cycles spent in the mode, digits typed so far
  int         m_mode = M_IDLE;
  int         m_cyc = 0;
  int         m_fail = 0;
  int         m_digits[$];
  logic [7:0] m_code = DEF_CODE;
  logic [3:0] m_prev = 4'b0;

  function automatic int code_digit(input logic [7:0] c, input int i);
    return int'((c >> (2 * i)) & 8'd3);
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE;
    m_cyc  = 0;
    m_fail = 0;
    m_code = DEF_CODE;
    m_prev = 4'b0;
    m_digits.delete();
  endtask

  task automatic model_step();
    logic [3:0] r;
    int         dig;
    bit         ev, ok, gr, lo, rd;
    gr = (m_mode == M_GRANT);
    lo = (m_mode == M_LOCK);
    rd = lo || ((m_mode == M_DENY) && (((m_cyc / TICK_DIV) % 2) == 0));
    r = btn & ~m_prev;
    m_prev = btn;
    ev = (r != 4'b0);
    dig = -1;
    if ($countones(r) == 1)
      for (int i = 0; i < 4; i++) if (r[i]) dig = i;
    case (m_mode)
      M_IDLE: begin
        if (ev) begin
          m_digits.delete();
          m_digits.push_back(dig);
          m_mode = M_ENTRY;
          m_cyc = 0;
        end else if (code_wr_en) begin
          m_code = code_wr_data;
        end
      end
      M_ENTRY: begin
        if (ev) begin
          m_digits.push_back(dig);
          m_cyc = 0;
          if (m_digits.size() == CODE_LEN) begin
            ok = 1;
            for (int i = 0; i < CODE_LEN; i++)
              if (m_digits[i] != code_digit(m_code, i)) ok = 0;
            if (ok) begin
              m_mode = M_GRANT;
              m_fail = 0;
            end else begin
              m_mode = M_DENY;
              if (m_fail < MAX_FAIL) m_fail++;
            end
          end
        end else begin
          m_cyc++;
          if (m_cyc == TIMEOUT_CYC) begin m_mode = M_IDLE; m_cyc = 0; end
        end
      end
      M_GRANT: begin
        m_cyc++;
        if (m_cyc == UNLOCK_CYC) begin m_mode = M_IDLE; m_cyc = 0; end
      end
      M_DENY: begin
        m_cyc++;
        if (m_cyc == DENY_CYC) begin
          m_mode = (m_fail == MAX_FAIL) ? M_LOCK : M_IDLE;
          m_cyc = 0;
        end
      end
      default: begin
        m_cyc++;
        if (m_cyc == LOCKOUT_CYC) begin m_mode = M_IDLE; m_cyc = 0; m_fail = 0; end
      end
    endcase
    exp_q.push_back({3'(m_mode), 2'(m_fail), lo, rd, gr, gr});
  endtask

  // Model advances on every clock edge; an asynchronous reset replaces the
  // pending expectation with the all-zero reset outputs.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_reset();
      exp_q.delete();
      if (clk) exp_q.push_back('0);
    end else begin
      model_step();
    end
  end

  // Monitor: one expected output vector per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = {state_o, fail_cnt, locked_out, red_led, green_led, unlock};
      checks++;
      if (mon_act !== mon_exp) begin
        errors++;
        $display("FAIL outputs t=%0t got={st,fail,lo,red,grn,unl}=%b expected=%b",
                 $time, mon_act, mon_exp);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge
  task automatic drive(input logic [3:0] b, input logic we, input logic [7:0] wd);
    @(posedge clk);
    #1;
    btn = b;
    code_wr_en = we;
    code_wr_data = wd;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(4'b0, 1'b0, 8'h00);
  endtask

  task automatic press(input int d);
    drive(4'(1 << d), 1'b0, 8'h00);
    drive(4'b0, 1'b0, 8'h00);
  endtask

  task automatic press_code(input logic [7:0] c);
    for (int i = 0; i < CODE_LEN; i++) press(code_digit(c, i));
  endtask

  task automatic random_attempt();
    int bad;
    bad = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, CODE_LEN - 1)) : -1;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (i == bad) begin
        if ($urandom_range(0, 1) == 0) drive(4'b0011, 1'b0, 8'h00);
        else drive(4'(1 << ((code_digit(m_code, i) + 1) % 4)), 1'b0, 8'h00);
      end else begin
        drive(4'(1 << code_digit(m_code, i)), 1'b0, 8'h00);
      end
      idle(int'($urandom_range(1, 3)));
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_unlock", {31'b0, unlock}, 32'd0);
    check("reset_state", {29'b0, state_o}, 32'd0);
    check("reset_fail", {30'b0, fail_cnt}, 32'd0);
    reset = 1'b0;
    idle(3);

    // Correct default code
    press_code(DEF_CODE);
    idle(16);

    // Wrong digit, judged only after the fourth press
    press(0); press(1); press(1); press(3);
    idle(20);

    // Two more failures reach lockout; correct code during lockout ignored
    press(3); press(3); press(3); press(3);
    idle(20);
    press(1); press(2); press(1); press(3);
    idle(22);
    press_code(DEF_CODE);
    idle(110);

    // Timeout after a single digit, then a full correct code
    press(0);
    idle(42);
    press_code(DEF_CODE);
    idle(16);

    // Two buttons rising together count as a wrong digit
    drive(4'b0101, 1'b0, 8'h00);
    drive(4'b0000, 1'b0, 8'h00);
    press(2); press(1); press(3);
    idle(20);

    // Write during ENTRY is dropped; default code still grants
    press(0);
    drive(4'b0, 1'b1, 8'h00);
    press(2); press(1); press(3);
    idle(16);

    // Write with a simultaneous press in IDLE is dropped
    drive(4'b0001, 1'b1, 8'hFF);
    drive(4'b0, 1'b0, 8'h00);
    idle(42);

    // Write in IDLE, then the new code grants
    drive(4'b0, 1'b1, 8'b00_01_10_11);
    idle(2);
    press_code(8'b00_01_10_11);
    idle(3);

    // Reset mid-GRANT drops outputs asynchronously
    @(posedge clk);
    #3;
    check("pre_reset_unlock", {31'b0, unlock}, 32'd1);
    reset = 1'b1;
    #1;
    check("async_unlock", {31'b0, unlock}, 32'd0);
    check("async_green", {31'b0, green_led}, 32'd0);
    check("async_red", {31'b0, red_led}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);

    // Code register back to default
    press_code(DEF_CODE);
    idle(16);

    // Randomized traffic
    for (int n = 0; n < 250; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: random_attempt();
        5: begin
          press(int'($urandom_range(0, 3)));
          idle(int'($urandom_range(30, 45)));
        end
        6: drive(4'b0, 1'b1, 8'($urandom_range(0, 255)));
        7: repeat ($urandom_range(1, 6)) drive(4'($urandom_range(0, 15)), 1'b0, 8'h00);
        8: idle(int'($urandom_range(1, 20)));
        default: idle(int'($urandom_range(20, 130)));
      endcase
    end
    idle(150);

    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
